imsharp_stream: RTL



---
 rtl/imsharp_pkg.sv | 30 +++
 rtl/imsharp_linebuf.sv | 37 +++
 rtl/imsharp_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/imsharp_pkg.sv
// Shared constants and helpers for the streaming 5x5 Gaussian unsharp sharpener.
// The kernel is symmetric and sums to KSUM; products accumulate in acc_w(PIX_W) bits.
package imsharp_pkg;

   localparam int unsigned K    = 5;
   localparam int unsigned KSUM = 4368;

   localparam int unsigned GK [K][K] = '{
      '{ 16,  64, 112,  64,  16},
      '{ 64, 256, 416, 256,  64},
      '{112, 416, 656, 416, 112},
      '{ 64, 256, 416, 256,  64},
      '{ 16,  64, 112,  64,  16}
   };

   // Full-scale window times KSUM never exceeds this width.
   function automatic int unsigned acc_w(input int unsigned pix_w);
      return pix_w + $clog2(KSUM);
   endfunction

   function automatic int unsigned sat_pix(input logic signed [31:0] d,
                                           input int unsigned       pix_w);
      int max_v;
      max_v = (1 << pix_w) - 1;
      if (d < 0) return 0;
      if (d > max_v) return unsigned'(max_v);
      return unsigned'(d);
   endfunction

endpackage

// File: rtl/imsharp_linebuf.sv
// Column-addressed buffer of the previous LINES image rows.
// On each enabled access the addressed column slides up one line and the new pixel enters last.
module imsharp_linebuf #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 64,
   parameter int unsigned LINES = 4,
   parameter int unsigned AW    = $clog2(IMG_W)
) (
   input  logic             clk_i,
   input  logic             en_i,
   input  logic [AW-1:0]    col_i,
   input  logic [PIX_W-1:0] pix_i,
   output logic [PIX_W-1:0] rd_o [LINES]
);

   logic [PIX_W-1:0] mem_q [LINES][IMG_W];
   logic [PIX_W-1:0] col_d [LINES];

   always_comb begin
      for (int unsigned l = 0; l < LINES; l++) begin
         rd_o[l] = mem_q[l][col_i];
      end
      for (int unsigned l = 0; l < LINES - 1; l++) begin
         col_d[l] = mem_q[l+1][col_i];
      end
      col_d[LINES-1] = pix_i;
   end

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int unsigned l = 0; l < LINES; l++) begin
            mem_q[l][col_i] <= col_d[l];
         end
      end
   end

endmodule

// File: rtl/imsharp_stream.sv
// Streaming 5x5 Gaussian unsharp sharpener: raster pixels in, sharpened interior pixels out.
// out = sat(2*centre - (conv >> SHIFT)), with a bypass that forwards the window centre.
module imsharp_stream
   import imsharp_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64,
   parameter int unsigned SHIFT = 12
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_last
);

   localparam int unsigned ACC_W = acc_w(PIX_W);
   localparam int unsigned CW    = $clog2(IMG_W);
   localparam int unsigned RW    = $clog2(IMG_H);

   logic en, hs, win_ok, last_px;
   logic [CW-1:0] col_q, col_d, pos_col;
   logic [RW-1:0] row_q, row_d, pos_row;

   logic [PIX_W-1:0] lb_rd [K-1];
   logic [PIX_W-1:0] win_q [K][K];
   logic [PIX_W-1:0] win_d [K][K];
   logic             s0_valid_q, s0_valid_d, s0_bypass_q, s0_bypass_d, s0_last_q, s0_last_d;

   logic [ACC_W-1:0] prod_q [K][K];
   logic [ACC_W-1:0] prod_d [K][K];
   logic [PIX_W-1:0] s1_centre_q, s1_centre_d;
   logic             s1_valid_q, s1_valid_d, s1_bypass_q, s1_bypass_d, s1_last_q, s1_last_d;

   logic [ACC_W-1:0] sum_q, sum_d, acc;
   logic [PIX_W-1:0] s2_centre_q, s2_centre_d;
   logic             s2_valid_q, s2_valid_d, s2_bypass_q, s2_bypass_d, s2_last_q, s2_last_d;

   logic [ACC_W+1:0]        twice_c, conv_sh;
   logic signed [ACC_W+1:0] diff;
   logic [PIX_W-1:0]        out_pixel_q, out_pixel_d;
   logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;

   // Counters and handshake; in_sof relocates the accepted pixel to (0,0).
   always_comb begin
      en      = !out_valid_q || out_ready;
      hs      = in_valid && en;
      pos_col = in_sof ? '0 : col_q;
      pos_row = in_sof ? '0 : row_q;
      win_ok  = !in_sof && (pos_row >= RW'(4)) && (pos_col >= CW'(4));
      last_px = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
      col_d   = col_q;
      row_d   = row_q;
      if (hs) begin
         if (pos_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
         end else begin
            col_d = pos_col + 1'b1;
            row_d = pos_row;
         end
      end
   end

   imsharp_linebuf #(
      .PIX_W(PIX_W),
      .IMG_W(IMG_W),
      .LINES(K - 1),
      .AW   (CW)
   ) u_linebuf (
      .clk_i(clk),
      .en_i (hs),
      .col_i(pos_col),
      .pix_i(in_pixel),
      .rd_o (lb_rd)
   );

   // S0: window shifts left; the rightmost column is the four buffered lines plus the new pixel.
   always_comb begin
      win_d       = win_q;
      s0_bypass_d = s0_bypass_q;
      s0_last_d   = s0_last_q;
      s0_valid_d  = s0_valid_q;
      if (en) s0_valid_d = hs && win_ok;
      if (hs) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         for (int unsigned r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = lb_rd[r];
         end
         win_d[K-1][K-1] = in_pixel;
         s0_bypass_d     = bypass;
         s0_last_d       = last_px;
      end
   end

   // S1 products and S2 sum.
   always_comb begin
      prod_d      = prod_q;
      s1_centre_d = s1_centre_q;
      s1_bypass_d = s1_bypass_q;
      s1_last_d   = s1_last_q;
      s1_valid_d  = s1_valid_q;
      acc         = '0;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K; c++) begin
            acc = acc + prod_q[r][c];
         end
      end
      sum_d       = sum_q;
      s2_centre_d = s2_centre_q;
      s2_bypass_d = s2_bypass_q;
      s2_last_d   = s2_last_q;
      s2_valid_d  = s2_valid_q;
      if (en) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
               prod_d[r][c] = ACC_W'(win_q[r][c]) * ACC_W'(GK[r][c]);
            end
         end
         s1_centre_d = win_q[2][2];
         s1_bypass_d = s0_bypass_q;
         s1_last_d   = s0_last_q;
         s1_valid_d  = s0_valid_q;
         sum_d       = acc;
         s2_centre_d = s1_centre_q;
         s2_bypass_d = s1_bypass_q;
         s2_last_d   = s1_last_q;
         s2_valid_d  = s1_valid_q;
      end
   end

   // S3: sharpen and clamp; the output register holds while stalled.
   always_comb begin
      twice_c     = (ACC_W + 2)'(s2_centre_q) << 1;
      conv_sh     = (ACC_W + 2)'(sum_q >> SHIFT);
      diff        = $signed(twice_c) - $signed(conv_sh);
      out_pixel_d = out_pixel_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (en) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            out_pixel_d = s2_bypass_q ? s2_centre_q : PIX_W'(sat_pix(32'(diff), PIX_W));
            out_last_d  = s2_last_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         col_q       <= '0;
         row_q       <= '0;
         s0_valid_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         s0_valid_q  <= s0_valid_d;
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk) begin
      win_q       <= win_d;
      s0_bypass_q <= s0_bypass_d;
      s0_last_q   <= s0_last_d;
      prod_q      <= prod_d;
      s1_centre_q <= s1_centre_d;
      s1_bypass_q <= s1_bypass_d;
      s1_last_q   <= s1_last_d;
      sum_q       <= sum_d;
      s2_centre_q <= s2_centre_d;
      s2_bypass_q <= s2_bypass_d;
      s2_last_q   <= s2_last_d;
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_last  = out_last_q;

endmodule
